ldpc_simd_pipe: RTL
===================

LDPC_SIMD_PIPE -- requirements
Module: ldpc_simd_pipe

Interface
REQ-001 Parameter Q, default 8: lane width in bits, two's-complement signed, range 4..16.
REQ-002 Parameter LANES, default 8: number of SIMD lanes; data width is W = Q*LANES.
REQ-003 Parameter SAT_MAX, default 63: saturation magnitude; results clip to [-SAT_MAX, +SAT_MAX]; must satisfy SAT_MAX <= 2^(Q-1)-1.
REQ-004 clk_i  in  1  single clock; reset is synchronous and active-high.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 in_valid_i  in  1  input beat valid.
REQ-007 in_ready_o  out  1  input beat accepted when in_valid_i and in_ready_o are both high.
REQ-008 op_i  in  3  ldpc_op_e: MIN, ADDSAT, SUBSAT, ACCMIN, ACCADD.
REQ-009 first_i  in  1  first beat of an accumulate packet; ignored for non-accumulate ops.
REQ-010 last_i  in  1  last beat of an accumulate packet; ignored for non-accumulate ops.
REQ-011 operand_a_i  in  W  packed lanes; lane i occupies bits [i*Q +: Q].
REQ-012 operand_b_i  in  W  packed lanes, same layout as operand_a_i.
REQ-013 out_valid_o  out  1  result valid.
REQ-014 out_ready_i  in  1  downstream accepts the result.
REQ-015 result_o  out  W  packed lane results.
REQ-016 sat_flag_o  out  LANES  per-lane flag: clipping occurred while producing result_o.

Function
REQ-017 Lane arithmetic SHALL be computed at Q+1 bits signed, then clipped to +/-SAT_MAX; lanes are independent, with no carry between lanes.
REQ-018 MIN SHALL return b when signed a >= b, otherwise a; on a tie it returns b; it never sets the lane's sat flag.
REQ-019 ADDSAT SHALL return clip(a+b); SUBSAT SHALL return clip(a-b); the lane flag is set when clipping occurs.
REQ-020 Non-accumulate ops SHALL have latency 1: the result is registered and out_valid_o rises in the cycle after acceptance.
REQ-021 in_ready_o SHALL equal (!out_valid_o || out_ready_i); a result and its flags SHALL hold stable while out_valid_o && !out_ready_i.
REQ-022 The FSM SHALL have two states, IDLE and ACC.
REQ-023 In IDLE, an accepted ACC* beat with first_i SHALL seed acc with lane-wise (a op b) and sticky flags with that beat's flags.
REQ-024 If that beat also has last_i, the FSM SHALL emit acc and stay in IDLE; otherwise it SHALL go to ACC and emit nothing.
REQ-025 In ACC, an accepted ACC* beat without first_i SHALL update acc to (acc op a) and OR its clip flags into the sticky flags; operand_b_i is ignored.
REQ-026 On such a beat with last_i, the FSM SHALL emit the updated acc and the sticky flags, then return to IDLE; otherwise it emits nothing.
REQ-027 An ACC* beat with first_i while in ACC SHALL abandon the current packet and re-seed per REQ-023 (restart).
REQ-028 An ACC* beat without first_i while in IDLE SHALL be consumed and dropped: no output and no acc change.
REQ-029 Non-accumulate ops accepted in ACC SHALL complete normally and leave acc, the sticky flags and the state untouched (interleaving allowed).
REQ-030 The op of each ACC beat SHALL be taken from op_i; ACCMIN uses MIN semantics and ACCADD uses ADDSAT semantics.
REQ-031 Non-emitting accumulate beats SHALL still require in_ready_o.
REQ-032 Throughput SHALL be one beat per cycle when out_ready_i is held high.

Reset
REQ-033 On rst_i high at a clock edge, the following SHALL clear: out_valid_o=0, result_o=0, sat_flag_o=0, acc=0, sticky flags=0, state=IDLE.
REQ-034 rst_i SHALL take priority over any simultaneous accepted beat; reset in mid-packet SHALL discard the packet with no output.
REQ-035 in_ready_o SHALL be 1 in the cycle after reset.

Structure
REQ-036 ldpc_op_e and the default parameter constants SHALL live in the shared ariane_pkg.
REQ-037 A combinational sub-module ldpc_simd_lane (one lane: min, saturating add/sub, clip flag) SHALL be instantiated LANES times.
REQ-038 The FSM, acc register and output register SHALL reside in ldpc_simd_pipe.

Verification (Q=8, SAT_MAX=63)
REQ-039 ADDSAT, lane0 50+20, lane1 10+5 -> next cycle: lane0=63, lane1=15, sat_flag_o=0x01.
REQ-040 SUBSAT, lane0 -50-30, lane2 -5-(-5) -> lane0=-63 with flag0=1; lane2=0 with flag2=0.
REQ-041 MIN, lane0 a=7 b=3 and lane1 a=-5 b=-5 -> lane0=3, lane1=-5, flags=0.
REQ-042 ACCMIN, 3 beats: beat1 (first) a=10 b=12, beat2 a=4, beat3 (last) a=9 -> exactly one out_valid_o pulse with lane=4; ACCADD 40+30 with first&last -> 63 with flag=1.
REQ-043 out_ready_i=0 for 3 cycles with a result pending -> in_ready_o=0 and result_o stable; out_ready_i=1 -> back-to-back beats accepted.
REQ-044 rst_i asserted after the first ACCMIN beat (a=1 b=2) -> no output; then a first&last beat a=20 b=30 -> 20.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared definitions for the LDPC SIMD datapath: opcode encoding, FSM states
// and default lane geometry.
package ariane_pkg;

   localparam int unsigned LDPC_Q_DEF       = 32'd8;
   localparam int unsigned LDPC_LANES_DEF   = 32'd8;
   localparam int unsigned LDPC_SAT_MAX_DEF = 32'd63;

   typedef enum logic [2:0] {
      OP_MIN    = 3'd0,
      OP_ADDSAT = 3'd1,
      OP_SUBSAT = 3'd2,
      OP_ACCMIN = 3'd3,
      OP_ACCADD = 3'd4
   } ldpc_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } ldpc_state_e;

   function automatic logic is_acc_op(input ldpc_op_e op);
      logic r;
      case (op)
         OP_ACCMIN, OP_ACCADD: r = 1'b1;
         default:              r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ldpc_simd_lane.sv
// One signed lane: min, saturating add or saturating subtract, clipped to
// +/-SAT_MAX with a flag reporting that clipping happened.
module ldpc_simd_lane
   import ariane_pkg::*;
#(
   parameter int unsigned Q       = LDPC_Q_DEF,
   parameter int unsigned SAT_MAX = LDPC_SAT_MAX_DEF
) (
   input  logic [Q-1:0] a_i,
   input  logic [Q-1:0] b_i,
   input  ldpc_op_e     op_i,
   output logic [Q-1:0] res_o,
   output logic         sat_o
);

   localparam logic signed [Q:0] POS_LIM = (Q+1)'(SAT_MAX);
   localparam logic signed [Q:0] NEG_LIM = -POS_LIM;

   logic signed [Q:0] a_ext_s;
   logic signed [Q:0] b_ext_s;
   logic signed [Q:0] raw_s;
   logic [Q-1:0]      min_s;
   logic              clip_en_s;

   // Lane arithmetic is one bit wider than the lane so add/sub never wrap.
   always_comb begin
      a_ext_s   = signed'({a_i[Q-1], a_i});
      b_ext_s   = signed'({b_i[Q-1], b_i});
      min_s     = ($signed(a_i) >= $signed(b_i)) ? b_i : a_i;
      raw_s     = '0;
      clip_en_s = 1'b0;
      res_o     = min_s;
      sat_o     = 1'b0;
      case (op_i)
         OP_ADDSAT, OP_ACCADD: begin
            raw_s     = a_ext_s + b_ext_s;
            clip_en_s = 1'b1;
         end
         OP_SUBSAT: begin
            raw_s     = a_ext_s - b_ext_s;
            clip_en_s = 1'b1;
         end
         default: begin
            clip_en_s = 1'b0;
         end
      endcase
      if (clip_en_s) begin
         if (raw_s > POS_LIM) begin
            res_o = POS_LIM[Q-1:0];
            sat_o = 1'b1;
         end else if (raw_s < NEG_LIM) begin
            res_o = NEG_LIM[Q-1:0];
            sat_o = 1'b1;
         end else begin
            res_o = raw_s[Q-1:0];
            sat_o = 1'b0;
         end
      end else begin
         res_o = min_s;
         sat_o = 1'b0;
      end
   end

endmodule

// File: rtl/ldpc_simd_pipe.sv
// SIMD LDPC check-node helper: per-lane min / saturating add / subtract with a
// one-deep registered output and a packet accumulator driven by a 2-state FSM.
module ldpc_simd_pipe
   import ariane_pkg::*;
#(
   parameter int unsigned Q       = LDPC_Q_DEF,
   parameter int unsigned LANES   = LDPC_LANES_DEF,
   parameter int unsigned SAT_MAX = LDPC_SAT_MAX_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  ldpc_op_e             op_i,
   input  logic                 first_i,
   input  logic                 last_i,
   input  logic [Q*LANES-1:0]   operand_a_i,
   input  logic [Q*LANES-1:0]   operand_b_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [Q*LANES-1:0]   result_o,
   output logic [LANES-1:0]     sat_flag_o
);

   localparam int unsigned W = Q * LANES;

   ldpc_state_e      state_q, state_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [LANES-1:0] sticky_q, sticky_d;
   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     result_q, result_d;
   logic [LANES-1:0] flag_q, flag_d;

   logic             accept_s;
   logic             chain_s;
   logic [W-1:0]     lane_a_s;
   logic [W-1:0]     lane_b_s;
   logic [W-1:0]     lane_res_s;
   logic [LANES-1:0] lane_sat_s;

   assign in_ready_o  = !out_valid_q || out_ready_i;
   assign accept_s    = in_valid_i && in_ready_o;
   assign out_valid_o = out_valid_q;
   assign result_o    = result_q;
   assign sat_flag_o  = flag_q;

   // A continuing accumulate beat folds operand_a into acc; otherwise lanes see a op b.
   always_comb begin
      chain_s = (state_q == ST_ACC) && is_acc_op(op_i) && !first_i;
      if (chain_s) begin
         lane_a_s = acc_q;
         lane_b_s = operand_a_i;
      end else begin
         lane_a_s = operand_a_i;
         lane_b_s = operand_b_i;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      ldpc_simd_lane #(
         .Q       (Q),
         .SAT_MAX (SAT_MAX)
      ) u_lane (
         .a_i   (lane_a_s[g*Q +: Q]),
         .b_i   (lane_b_s[g*Q +: Q]),
         .op_i  (op_i),
         .res_o (lane_res_s[g*Q +: Q]),
         .sat_o (lane_sat_s[g])
      );
   end

   // Next-state, accumulator and output-register update.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      sticky_d    = sticky_q;
      out_valid_d = out_valid_q && !out_ready_i;
      result_d    = result_q;
      flag_d      = flag_q;
      if (accept_s) begin
         if (!is_acc_op(op_i)) begin
            out_valid_d = 1'b1;
            result_d    = lane_res_s;
            flag_d      = lane_sat_s;
         end else if (first_i) begin
            acc_d    = lane_res_s;
            sticky_d = lane_sat_s;
            if (last_i) begin
               out_valid_d = 1'b1;
               result_d    = lane_res_s;
               flag_d      = lane_sat_s;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_ACC;
            end
         end else begin
            case (state_q)
               ST_ACC: begin
                  acc_d    = lane_res_s;
                  sticky_d = sticky_q | lane_sat_s;
                  if (last_i) begin
                     out_valid_d = 1'b1;
                     result_d    = lane_res_s;
                     flag_d      = sticky_q | lane_sat_s;
                     state_d     = ST_IDLE;
                  end else begin
                     state_d = ST_ACC;
                  end
               end
               ST_IDLE: begin
                  // Stray continuation beat outside a packet: consumed, no effect.
                  state_d = ST_IDLE;
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
      end else begin
         state_d = state_q;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         sticky_q    <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flag_q      <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         sticky_q    <= sticky_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flag_q      <= flag_d;
      end
   end

endmodule
